// File: rtl/fb_arb_pkg.sv
// Shared types and helpers for the frame-buffer SDRAM arbiter.
package fb_arb_pkg;

  typedef enum logic [1:0] {IDLE, RD_CMD, WR_BURST} state_t;
  typedef enum logic {GNT_RD, GNT_WR} grant_t;

  localparam int unsigned BC_MAX_W = 16;

  // A zero burstcount is serviced as a single beat.
  function automatic logic [BC_MAX_W-1:0] norm_bc(input logic [BC_MAX_W-1:0] bc);
    return (bc == '0) ? BC_MAX_W'(1) : bc;
  endfunction

endpackage

// File: rtl/fb_arb_grant.sv
// IDLE-cycle grant decision: round-robin, urgent-read priority and writer starvation guard.
module fb_arb_grant
  import fb_arb_pkg::*;
#(
  parameter int unsigned MAX_RD_STREAK = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   decide,
  input  logic   rd_req,
  input  logic   wr_req,
  input  logic   rd_urgent,
  input  logic   rd_done,
  input  logic   wr_done,
  output grant_t grant
);

  localparam int unsigned SW = (MAX_RD_STREAK < 1) ? 1 : $clog2(MAX_RD_STREAK + 1);

  logic [SW-1:0] streak;
  logic [SW-1:0] streak_n;
  grant_t        last_grant;

  always_comb begin
    grant    = GNT_RD;
    streak_n = streak;
    if (rd_req && !wr_req) begin
      grant    = GNT_RD;
      streak_n = '0;
    end else if (!rd_req && wr_req) begin
      grant    = GNT_WR;
      streak_n = '0;
    end else if (rd_req && wr_req) begin
      if (rd_urgent) begin
        if (streak < SW'(MAX_RD_STREAK)) begin
          grant    = GNT_RD;
          streak_n = streak + SW'(1);
        end else begin
          grant    = GNT_WR;
          streak_n = '0;
        end
      end else begin
        // Non-urgent contention alternates; a read win here leaves the streak alone.
        grant = (last_grant == GNT_WR) ? GNT_RD : GNT_WR;
        if (grant == GNT_WR) streak_n = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak     <= '0;
      last_grant <= GNT_WR;
    end else begin
      if (decide && (rd_req || wr_req)) streak <= streak_n;
      if (rd_done)      last_grant <= GNT_RD;
      else if (wr_done) last_grant <= GNT_WR;
    end
  end

endmodule

// File: rtl/fb_sdram_arbiter.sv
// Burst-granular arbiter sharing one SDRAM Avalon-MM slave between display read and camera write DMA.
module fb_sdram_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 25,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned BC_W          = 8,
  parameter int unsigned MAX_RD_STREAK = 4,
  parameter int unsigned PEND_W        = 10
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   rd_address,
  input  logic                rd_read,
  input  logic [BC_W-1:0]     rd_burstcount,
  input  logic                rd_urgent,
  output logic                rd_waitrequest,
  output logic [DATA_W-1:0]   rd_readdata,
  output logic                rd_readdatavalid,
  input  logic [ADDR_W-1:0]   wr_address,
  input  logic                wr_write,
  input  logic [DATA_W-1:0]   wr_writedata,
  input  logic [DATA_W/8-1:0] wr_byteenable,
  input  logic [BC_W-1:0]     wr_burstcount,
  output logic                wr_waitrequest,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [BC_W-1:0]     m_burstcount,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic [PEND_W-1:0]   rd_pending
);

  state_t            state, state_n;
  grant_t            grant;
  logic              idle;
  logic              rd_accept, wr_accept, rd_done, wr_done;
  logic [BC_W-1:0]   rd_bc, wr_bc;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [BC_W-1:0]   wr_bc_q;
  logic [BC_W-1:0]   beat_cnt;
  logic [PEND_W:0]   pend_sum;

  assign idle  = (state == IDLE);
  assign rd_bc = BC_W'(norm_bc(BC_MAX_W'(rd_burstcount)));
  assign wr_bc = BC_W'(norm_bc(BC_MAX_W'(wr_burstcount)));

  assign rd_readdata      = m_readdata;
  assign rd_readdatavalid = m_readdatavalid;
  assign m_writedata      = wr_writedata;
  assign m_byteenable     = wr_byteenable;

  fb_arb_grant #(.MAX_RD_STREAK(MAX_RD_STREAK)) u_grant (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .decide    (idle),
    .rd_req    (rd_read),
    .wr_req    (wr_write),
    .rd_urgent (rd_urgent),
    .rd_done   (rd_done),
    .wr_done   (wr_done),
    .grant     (grant)
  );

  always_comb begin
    state_n        = state;
    m_address      = '0;
    m_burstcount   = '0;
    m_read         = 1'b0;
    m_write        = 1'b0;
    rd_waitrequest = 1'b1;
    wr_waitrequest = 1'b1;
    rd_accept      = 1'b0;
    wr_accept      = 1'b0;
    rd_done        = 1'b0;
    wr_done        = 1'b0;
    case (state)
      IDLE: begin
        if (rd_read || wr_write) state_n = (grant == GNT_RD) ? RD_CMD : WR_BURST;
      end
      RD_CMD: begin
        m_address      = rd_address;
        m_burstcount   = rd_bc;
        m_read         = rd_read;
        rd_waitrequest = m_waitrequest;
        rd_accept      = rd_read && !m_waitrequest;
        rd_done        = rd_accept;
        if (rd_accept || !rd_read) state_n = IDLE;
      end
      WR_BURST: begin
        m_address      = wr_addr_q;
        m_burstcount   = wr_bc_q;
        m_write        = wr_write;
        wr_waitrequest = m_waitrequest;
        wr_accept      = wr_write && !m_waitrequest;
        wr_done        = wr_accept && (beat_cnt == BC_W'(1));
        if (wr_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Add and retire in one step so a same-cycle command and return beat net correctly.
  assign pend_sum = (PEND_W+1)'(rd_pending) + (rd_accept ? (PEND_W+1)'(rd_bc) : '0);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      wr_addr_q  <= '0;
      wr_bc_q    <= '0;
      beat_cnt   <= '0;
      rd_pending <= '0;
    end else begin
      state <= state_n;
      if (idle && (state_n == WR_BURST)) begin
        wr_addr_q <= wr_address;
        wr_bc_q   <= wr_bc;
        beat_cnt  <= wr_bc;
      end else if (wr_accept) begin
        beat_cnt <= beat_cnt - BC_W'(1);
      end
      if (m_readdatavalid && (pend_sum != '0))
        rd_pending <= PEND_W'(pend_sum - (PEND_W+1)'(1));
      else
        rd_pending <= PEND_W'(pend_sum);
    end
  end

endmodule

// File: tb/tb_fb_sdram_arbiter.sv
// Self-checking bench for fb_sdram_arbiter: directed steps followed by a randomized run against a reference model.
module tb_fb_sdram_arbiter;

  localparam int unsigned ADDR_W        = 25;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned BC_W          = 8;
  localparam int unsigned MAX_RD_STREAK = 4;
  localparam int unsigned PEND_W        = 10;
  localparam int unsigned BE_W          = DATA_W / 8;

  logic              clk_clk          = 1'b0;
  logic              reset_reset_n    = 1'b0;
  logic [ADDR_W-1:0] rd_address       = '0;
  logic              rd_read          = 1'b0;
  logic [BC_W-1:0]   rd_burstcount    = '0;
  logic              rd_urgent        = 1'b0;
  logic              rd_waitrequest;
  logic [DATA_W-1:0] rd_readdata;
  logic              rd_readdatavalid;
  logic [ADDR_W-1:0] wr_address       = '0;
  logic              wr_write         = 1'b0;
  logic [DATA_W-1:0] wr_writedata     = '0;
  logic [BE_W-1:0]   wr_byteenable    = '0;
  logic [BC_W-1:0]   wr_burstcount    = '0;
  logic              wr_waitrequest;
  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic              m_write;
  logic [DATA_W-1:0] m_writedata;
  logic [BE_W-1:0]   m_byteenable;
  logic [BC_W-1:0]   m_burstcount;
  logic              m_waitrequest    = 1'b0;
  logic [DATA_W-1:0] m_readdata       = '0;
  logic              m_readdatavalid  = 1'b0;
  logic [PEND_W-1:0] rd_pending;

  fb_sdram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BC_W(BC_W),
    .MAX_RD_STREAK(MAX_RD_STREAK), .PEND_W(PEND_W)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .rd_address(rd_address), .rd_read(rd_read), .rd_burstcount(rd_burstcount),
    .rd_urgent(rd_urgent), .rd_waitrequest(rd_waitrequest), .rd_readdata(rd_readdata),
    .rd_readdatavalid(rd_readdatavalid),
    .wr_address(wr_address), .wr_write(wr_write), .wr_writedata(wr_writedata),
    .wr_byteenable(wr_byteenable), .wr_burstcount(wr_burstcount), .wr_waitrequest(wr_waitrequest),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_burstcount(m_burstcount), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .rd_pending(rd_pending)
  );

  always #5 clk_clk = ~clk_clk;

  int total = 0;
  int bad   = 0;
  int gq[$];

  // reference-model state for the randomized run
  bit                rd_busy, wr_busy, wr_started, wr_hold;
  bit                prev_r, prev_w, prev_u, prev_mread;
  bit                new_rd, new_wr, rd_acc, wr_acc;
  int                m_pend, m_streak, m_last, exp_g;
  int unsigned       rd_n, wr_total, wr_left;
  logic [ADDR_W-1:0] rd_a, wr_a;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rd_read = 1'b0; wr_write = 1'b0; rd_urgent = 1'b0;
    m_readdatavalid = 1'b0; m_waitrequest = 1'b0;
    reset_reset_n = 1'b0;
    tick(); tick();
    reset_reset_n = 1'b1;
    settle();
  endtask

  task automatic issue_read(input string tag, input logic [ADDR_W-1:0] a, input logic [BC_W-1:0] bc,
                            input logic [BC_W-1:0] exp_bc, input logic vld);
    rd_address = a; rd_burstcount = bc; rd_read = 1'b1;
    settle();
    check({tag, "_idle_mread"}, m_read, 1'b0);
    check({tag, "_idle_rwait"}, rd_waitrequest, 1'b1);
    tick();
    check({tag, "_mread"}, m_read, 1'b1);
    check({tag, "_addr"}, m_address, a);
    check({tag, "_bc"}, m_burstcount, exp_bc);
    check({tag, "_rwait"}, rd_waitrequest, 1'b0);
    m_readdatavalid = vld;
    tick();
    rd_read = 1'b0; m_readdatavalid = 1'b0;
    settle();
  endtask

  task automatic wr_beat(input string tag, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be,
                         input logic [ADDR_W-1:0] a, input logic [BC_W-1:0] bc);
    wr_writedata = d; wr_byteenable = be;
    settle();
    check({tag, "_mwrite"}, m_write, 1'b1);
    check({tag, "_wdata"}, m_writedata, d);
    check({tag, "_be"}, m_byteenable, be);
    check({tag, "_addr"}, m_address, a);
    check({tag, "_bc"}, m_burstcount, bc);
    check({tag, "_wwait"}, wr_waitrequest, 1'b0);
    tick();
  endtask

  task automatic collect(input int n);
    gq.delete();
    for (int c = 0; c < 200 && gq.size() < n; c++) begin
      settle();
      if (m_read) gq.push_back(0);
      else if (m_write) gq.push_back(1);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    // reset state and always-forwarded return path
    tick();
    m_readdata = 32'hA5A5_0001; m_readdatavalid = 1'b1;
    settle();
    check("rst_mread", m_read, 1'b0);
    check("rst_mwrite", m_write, 1'b0);
    check("rst_rwait", rd_waitrequest, 1'b1);
    check("rst_wwait", wr_waitrequest, 1'b1);
    check("rst_pend", rd_pending, 0);
    check("rst_rdata", rd_readdata, 32'hA5A5_0001);
    check("rst_rvalid", rd_readdatavalid, 1'b1);
    m_readdatavalid = 1'b0;
    reset_reset_n = 1'b1;
    tick();

    // read-only burst of 8, then drain and saturate
    issue_read("rd8", 25'h0_1234, 8'd8, 8'd8, 1'b0);
    check("rd8_pend", rd_pending, 8);
    for (int i = 0; i < 8; i++) begin
      m_readdatavalid = 1'b1; m_readdata = 32'h5000_0000 + i;
      settle();
      check("rd8_rdata", rd_readdata, 32'h5000_0000 + i);
      tick();
      check("rd8_drain", rd_pending, 7 - i);
    end
    tick();
    check("pend_saturate", rd_pending, 0);
    m_readdatavalid = 1'b0;

    // zero burstcount reads
    issue_read("rd3", 25'h0_0100, 8'd3, 8'd3, 1'b0);
    check("rd3_pend", rd_pending, 3);
    issue_read("bc0v", 25'h0_0104, 8'd0, 8'd1, 1'b1);
    check("bc0_same_cycle_pend", rd_pending, 3);
    issue_read("bc0", 25'h0_0108, 8'd0, 8'd1, 1'b0);
    check("bc0_pend", rd_pending, 4);
    m_readdatavalid = 1'b1;
    repeat (5) tick();
    m_readdatavalid = 1'b0;
    check("bc0_drain", rd_pending, 0);

    // write burst of 4 with a two-cycle stall on beat 2
    wr_address = 25'h0_1000; wr_burstcount = 8'd4;
    wr_writedata = 32'hCAFE_0000; wr_byteenable = 4'hF; wr_write = 1'b1;
    settle();
    check("wr_idle_wwait", wr_waitrequest, 1'b1);
    check("wr_idle_mwrite", m_write, 1'b0);
    tick();
    wr_address = 25'h1_FFFF; wr_burstcount = 8'hFF;
    wr_beat("wr_b0", 32'hCAFE_0000, 4'hF, 25'h0_1000, 8'd4);
    m_waitrequest = 1'b1; wr_writedata = 32'hCAFE_0001; wr_byteenable = 4'h3;
    for (int s = 0; s < 2; s++) begin
      settle();
      check("wr_stall_wwait", wr_waitrequest, 1'b1);
      check("wr_stall_mwrite", m_write, 1'b1);
      tick();
    end
    m_waitrequest = 1'b0;
    wr_beat("wr_b1", 32'hCAFE_0001, 4'h3, 25'h0_1000, 8'd4);
    wr_beat("wr_b2", 32'hCAFE_0002, 4'hC, 25'h0_1000, 8'd4);
    wr_beat("wr_b3", 32'hCAFE_0003, 4'h5, 25'h0_1000, 8'd4);
    wr_write = 1'b0;
    settle();
    check("wr_end_mwrite", m_write, 1'b0);
    check("wr_end_wwait", wr_waitrequest, 1'b1);

    // asynchronous reset during beat 2 of an 8-beat write
    wr_address = 25'h0_2000; wr_burstcount = 8'd8; wr_write = 1'b1;
    settle();
    tick();
    wr_beat("rst_b0", 32'hBEEF_0000, 4'hF, 25'h0_2000, 8'd8);
    wr_writedata = 32'hBEEF_0001;
    settle();
    check("rst_b1_mwrite", m_write, 1'b1);
    reset_reset_n = 1'b0;
    #1;
    check("rst_async_mwrite", m_write, 1'b0);
    check("rst_async_wwait", wr_waitrequest, 1'b1);
    check("rst_async_rwait", rd_waitrequest, 1'b1);
    tick();
    reset_reset_n = 1'b1;
    wr_address = 25'h0_3000;
    settle();
    check("rst_idle_wwait", wr_waitrequest, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) wr_beat("fresh", 32'hD00D_0000 + i, 4'hF, 25'h0_3000, 8'd8);
    wr_write = 1'b0;
    settle();
    check("fresh_end_mwrite", m_write, 1'b0);
    check("fresh_end_wwait", wr_waitrequest, 1'b1);

    // round-robin under continuous contention
    do_reset();
    rd_address = 25'h0_4000; rd_burstcount = 8'd1;
    wr_address = 25'h0_5000; wr_burstcount = 8'd1;
    rd_read = 1'b1; wr_write = 1'b1;
    collect(4);
    check("alt_count", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) check($sformatf("alt_g%0d", i), gq[i], i % 2);

    // urgent reads with starvation guard
    do_reset();
    rd_urgent = 1'b1; rd_read = 1'b1; wr_write = 1'b1;
    collect(10);
    check("urg_count", gq.size(), 10);
    for (int i = 0; i < 10 && i < gq.size(); i++)
      check($sformatf("urg_g%0d", i), gq[i], (i == 4 || i == 9) ? 1 : 0);

    // randomized traffic against the reference model
    do_reset();
    m_pend = 0; m_streak = 0; m_last = 1;
    rd_busy = 0; wr_busy = 0; wr_started = 0; wr_hold = 0;
    prev_r = 0; prev_w = 0; prev_u = 0; prev_mread = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      m_waitrequest   = ($urandom_range(0, 3) == 0);
      m_readdatavalid = ($urandom_range(0, 2) == 0);
      m_readdata      = $urandom;
      rd_urgent       = ($urandom_range(0, 1) == 1);
      if (!rd_busy && $urandom_range(0, 2) == 0) begin
        rd_busy = 1; rd_a = ADDR_W'($urandom);
        rd_burstcount = BC_W'($urandom_range(0, 6));
        rd_n = (rd_burstcount == 0) ? 1 : rd_burstcount;
        rd_address = rd_a; rd_read = 1'b1;
      end
      if (!wr_busy && $urandom_range(0, 2) == 0) begin
        wr_busy = 1; wr_started = 0; wr_a = ADDR_W'($urandom);
        wr_burstcount = BC_W'($urandom_range(0, 5));
        wr_total = (wr_burstcount == 0) ? 1 : wr_burstcount;
        wr_left = wr_total;
        wr_address = wr_a; wr_writedata = $urandom; wr_byteenable = BE_W'($urandom);
        wr_write = 1'b1;
      end else if (wr_busy && wr_started && !wr_hold) begin
        wr_write = ($urandom_range(0, 3) != 0);
      end
      settle();
      new_rd = m_read && !prev_mread;
      new_wr = m_write && wr_busy && !wr_started;
      if (new_rd || new_wr) begin
        if (prev_r && !prev_w) begin exp_g = 0; m_streak = 0; end
        else if (!prev_r && prev_w) begin exp_g = 1; m_streak = 0; end
        else if (prev_u) begin
          if (m_streak < MAX_RD_STREAK) begin exp_g = 0; m_streak++; end
          else begin exp_g = 1; m_streak = 0; end
        end else begin
          exp_g = (m_last == 1) ? 0 : 1;
          if (exp_g == 1) m_streak = 0;
        end
        check("rnd_grant", new_wr ? 1 : 0, exp_g);
        m_last = exp_g;
      end
      if (new_wr) wr_started = 1;
      if (m_read) begin
        check("rnd_rd_addr", m_address, rd_a);
        check("rnd_rd_bc", m_burstcount, rd_n);
      end
      if (m_write) begin
        check("rnd_wr_addr", m_address, wr_a);
        check("rnd_wr_bc", m_burstcount, wr_total);
        check("rnd_wr_data", m_writedata, wr_writedata);
        check("rnd_wr_be", m_byteenable, wr_byteenable);
      end
      check("rnd_rwait", rd_waitrequest, m_read ? m_waitrequest : 1'b1);
      check("rnd_wwait", wr_waitrequest, wr_started ? m_waitrequest : 1'b1);
      check("rnd_pend", rd_pending, m_pend);
      check("rnd_rvalid", rd_readdatavalid, m_readdatavalid);
      rd_acc = m_read && !m_waitrequest;
      wr_acc = m_write && !m_waitrequest;
      m_pend = m_pend + (rd_acc ? int'(rd_n) : 0);
      if (m_readdatavalid && m_pend > 0) m_pend--;
      prev_r = rd_read; prev_w = wr_write; prev_u = rd_urgent; prev_mread = m_read;
      wr_hold = wr_write && !wr_acc;
      tick();
      if (rd_acc) begin rd_busy = 0; rd_read = 1'b0; end
      if (wr_acc) begin
        wr_left--;
        wr_writedata = $urandom; wr_byteenable = BE_W'($urandom);
        if (wr_left == 0) begin
          wr_busy = 0; wr_started = 0; wr_hold = 0; wr_write = 1'b0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
